// File: rtl/multi_sprite_engine_if.sv
// multi_sprite_engine_if: register-write bus and sprite-ROM port of the sprite engine.
interface multi_sprite_engine_if #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int IMG_BITS    = 2
);
  localparam int AW = $clog2(NUM_SPRITES) + 2;
  localparam int LW = $clog2(SPRITE_H);
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [9:0]            wr_data;
  logic [IMG_BITS-1:0]   rom_image;
  logic [LW-1:0]         rom_line;
  logic [4*SPRITE_W-1:0] rom_bits;
  modport master (output wr_en, wr_addr, wr_data, rom_bits, input rom_image, rom_line);
  modport slave (input wr_en, wr_addr, wr_data, rom_bits, output rom_image, rom_line);
endinterface

// File: rtl/multi_sprite_engine.sv
// multi_sprite_engine: composites NUM_SPRITES line-buffered sprites onto the VGA raster,
// with per-frame shadow registers, an hsync line-fetch FSM and per-frame collision flags.
module multi_sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int IMG_BITS    = 2,
  parameter int V_TOTAL     = 525
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos_i,
  input  logic [9:0]             vpos_i,
  input  logic                   load_i,
  input  logic                   frame_start_i,
  multi_sprite_engine_if.slave   bus,
  output logic                   red_o,
  output logic                   green_o,
  output logic                   blue_o,
  output logic                   alpha_o,
  output logic                   busy_o,
  output logic [NUM_SPRITES-1:0] collision_o
);
  localparam int N  = NUM_SPRITES;
  localparam int BW = 4 * SPRITE_W;
  localparam int LW = $clog2(SPRITE_H);
  localparam int AW = $clog2(N) + 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t              state_q, state_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic                load_q, hit;
  logic [9:0]          tline, row;
  logic [1:0]          fld;
  logic [9:0]          shx_q [N], shx_d [N], shy_q [N], shy_d [N], ax_q [N], ay_q [N];
  logic [IMG_BITS-1:0] shimg_q [N], shimg_d [N], aimg_q [N];
  logic [N-1:0]        wsel, shen_q, shen_d, aen_q, arm_q, arm_d, on, opq, hits, acc_q, col_q;
  logic [BW-1:0]       buf_q [N];
  logic [9:0]          off [N];
  logic [3:0]          pix [N];
  logic [3:0]          rgba_q, rgba_d;
  assign fld = bus.wr_addr[1:0];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wsel[i] = bus.wr_en && ((bus.wr_addr >> 2) == AW'(i));
      shx_d[i] = (wsel[i] && fld == 2'd0) ? bus.wr_data : shx_q[i];
      shy_d[i] = (wsel[i] && fld == 2'd1) ? bus.wr_data : shy_q[i];
      shen_d[i] = (wsel[i] && fld == 2'd2) ? bus.wr_data[IMG_BITS] : shen_q[i];
      shimg_d[i] = (wsel[i] && fld == 2'd2) ? bus.wr_data[IMG_BITS-1:0] : shimg_q[i];
    end
  end
  // Fetch prepares the line after the current one, wrapping at the frame end.
  assign tline = (vpos_i == 10'(V_TOTAL - 1)) ? 10'd0 : vpos_i + 10'd1;
  assign row = tline - ay_q[idx_q];
  assign hit = (state_q == FETCH) && aen_q[idx_q] && (row < 10'(SPRITE_H));
  assign bus.rom_line = hit ? row[LW-1:0] : '0;
  assign bus.rom_image = hit ? aimg_q[idx_q] : '0;
  always_comb begin
    state_d = (state_q == IDLE && load_i && !load_q) ? FETCH :
              (state_q == FETCH && idx_q == CW'(N - 1)) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    idx_d = (state_q == FETCH) ? idx_q + 1'b1 : '0;
  end
  // Walking downwards lets the lowest-index opaque channel overwrite the rest.
  always_comb begin
    rgba_d = '0;
    for (int i = N - 1; i >= 0; i--) begin
      off[i] = hpos_i - ax_q[i];
      on[i] = arm_q[i] && (hpos_i >= ax_q[i]) && (off[i] < 10'(SPRITE_W));
      pix[i] = buf_q[i][BW - 1 - 4 * off[i][KW-1:0] -: 4];
      opq[i] = on[i] && pix[i][0];
      rgba_d = opq[i] ? pix[i] : rgba_d;
      arm_d[i] = (state_q == FETCH && idx_q == CW'(i)) ? hit :
                 (on[i] && (off[i] == 10'(SPRITE_W - 1) || hpos_i == 10'd1023)) ? 1'b0 : arm_q[i];
    end
    hits = ($countones(opq) > 1) ? opq : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      load_q <= 1'b0;
      shen_q <= '0;
      aen_q <= '0;
      arm_q <= '0;
      acc_q <= '0;
      col_q <= '0;
      rgba_q <= '0;
      for (int i = 0; i < N; i++) begin
        shx_q[i] <= '0;
        shy_q[i] <= '0;
        shimg_q[i] <= '0;
        ax_q[i] <= '0;
        ay_q[i] <= '0;
        aimg_q[i] <= '0;
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      load_q <= load_i;
      shen_q <= shen_d;
      arm_q <= arm_d;
      rgba_q <= rgba_d;
      acc_q <= frame_start_i ? '0 : (acc_q | hits);
      if (frame_start_i) col_q <= acc_q | hits;
      if (frame_start_i) aen_q <= shen_d;
      for (int i = 0; i < N; i++) begin
        shx_q[i] <= shx_d[i];
        shy_q[i] <= shy_d[i];
        shimg_q[i] <= shimg_d[i];
        if (frame_start_i) begin
          ax_q[i] <= shx_d[i];
          ay_q[i] <= shy_d[i];
          aimg_q[i] <= shimg_d[i];
        end
        if (hit && idx_q == CW'(i)) buf_q[i] <= bus.rom_bits;
      end
    end
  end
  assign {red_o, green_o, blue_o, alpha_o} = rgba_q;
  assign busy_o = state_q != IDLE;
  assign collision_o = col_q;
endmodule
